// File: rtl/rr_mux_sel_arbiter_if.sv
// Requester/arbiter bundle for rr_mux_sel_arbiter.
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface rr_mux_sel_arbiter_if;
   logic [3:0] req;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;
`ifdef RR_ARB_LOCK_EN
   logic       lock;

   modport master (output req, output lock, input sel, input grant, input busy);
   modport slave  (input req, input lock, output sel, output grant, output busy);
`else
   modport master (output req, input sel, input grant, input busy);
   modport slave  (input req, output sel, output grant, output busy);
`endif
endinterface

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter that drives the select pair of a 4:1 mux, with bounded bursts.
// Optional feature macro: RR_ARB_LOCK_EN (adds lock, which can extend a burst indefinitely).
module rr_mux_sel_arbiter #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   rr_mux_sel_arbiter_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       sel_q;
   logic [3:0]       grant_q;
   logic             busy_q;
   logic [CNT_W-1:0] cnt;

   logic             lock_hold;
   logic             rel;
   logic [1:0]       scan_base;
   logic [1:0]       idx;
   logic [1:0]       winner;
   logic             found;

   // When a burst is released, arbitration scans from the advanced pointer in the same cycle.
   always_comb begin
      lock_hold = 1'b0;
`ifdef RR_ARB_LOCK_EN
      lock_hold = bus.lock && bus.req[sel_q];
`endif
      rel       = (state == GRANT) && (!bus.req[sel_q] || ((cnt == '0) && !lock_hold));
      scan_base = rel ? (sel_q + 2'd1) : ptr;
      found     = 1'b0;
      winner    = 2'd0;
      idx       = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = scan_base + 2'(k);
         if (!found && bus.req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // sel is left untouched whenever the arbiter goes idle so the mux never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         sel_q   <= 2'd0;
         grant_q <= 4'b0000;
         busy_q  <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  state   <= GRANT;
                  sel_q   <= winner;
                  grant_q <= 4'b0001 << winner;
                  busy_q  <= 1'b1;
                  cnt     <= HOLD_M1;
               end
            end
            GRANT: begin
               if (rel) begin
                  ptr <= sel_q + 2'd1;
                  if (found) begin
                     sel_q   <= winner;
                     grant_q <= 4'b0001 << winner;
                     cnt     <= HOLD_M1;
                  end else begin
                     state   <= IDLE;
                     grant_q <= 4'b0000;
                     busy_q  <= 1'b0;
                  end
               end else if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel   = sel_q;
   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;

endmodule
